// File: rtl/noc_perf_monitor_pkg.sv
// Shared types and constants for the NoC layer-completion / performance monitor.
package my_pkg;
  localparam int MESH_SIZE = 2;

  typedef enum logic [1:0] {MON_IDLE, MON_RUN, MON_FIN} mon_state_t;

  localparam logic [1:0] RD_CYCLES   = 2'd0;
  localparam logic [1:0] RD_STALL    = 2'd1;
  localparam logic [1:0] RD_CONFLICT = 2'd2;
  localparam logic [1:0] RD_FINISH   = 2'd3;
endpackage

// File: rtl/noc_perf_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst || clr)              q <= '0;
    else if (inc && (q != '1))   q <= q + 1'b1;
  end
endmodule

// File: rtl/noc_perf_monitor.sv
// Layer-completion and performance monitor downstream of the NoC mesh:
// per-PE stall/conflict counts, per-PE finish cycle, and a registered read port.
module noc_perf_monitor #(
  parameter int               MESH_SIZE  = my_pkg::MESH_SIZE,
  parameter int               PE_NUMBER  = MESH_SIZE*MESH_SIZE,
  parameter int               CNT_W      = 32,
  parameter logic [CNT_W-1:0] TIMEOUT_CC = '1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [PE_NUMBER-1:0]         done_i,
  input  logic [PE_NUMBER-1:0]         stall_i,
  input  logic [PE_NUMBER-1:0]         conflict_i,
  output logic                         busy_o,
  output logic                         layer_finished_o,
  output logic                         timeout_o,
  input  logic                         rd_en,
  input  logic [1:0]                   rd_kind,
  input  logic [$clog2(PE_NUMBER)-1:0] rd_idx,
  output logic                         rd_valid,
  output logic [CNT_W-1:0]             rd_data
);
  import my_pkg::*;

  mon_state_t                          state;
  logic [PE_NUMBER-1:0]                seen;
  logic [CNT_W-1:0]                    cycle_q, n, rd_mux;
  logic [PE_NUMBER-1:0][CNT_W-1:0]     stall_q, conf_q, fin_q;
  logic                                run, clr, all_done, tmo_hit;

  assign run      = (state == MON_RUN);
  assign clr      = start && !run;
  assign n        = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;
  assign all_done = &(seen | done_i);
  // TIMEOUT_CC of 0 can never match since n >= 1, so it disables the timeout.
  assign tmo_hit  = run && !all_done && (n == TIMEOUT_CC);
  assign busy_o   = run;

  sat_counter #(.CNT_W(CNT_W)) u_cycle (
    .clk(clk), .rst(rst), .clr(clr), .inc(run), .q(cycle_q)
  );

  // The finish counter tracks cycle_cnt until its PE is seen, then freezes,
  // which leaves exactly n from the stamping cycle. It is masked by seen on reads.
  for (genvar i = 0; i < PE_NUMBER; i++) begin : g_pe
    sat_counter #(.CNT_W(CNT_W)) u_stall (
      .clk(clk), .rst(rst), .clr(clr), .inc(run && stall_i[i]), .q(stall_q[i])
    );
    sat_counter #(.CNT_W(CNT_W)) u_conf (
      .clk(clk), .rst(rst), .clr(clr), .inc(run && conflict_i[i]), .q(conf_q[i])
    );
    sat_counter #(.CNT_W(CNT_W)) u_fin (
      .clk(clk), .rst(rst), .clr(clr), .inc(run && !seen[i]), .q(fin_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= MON_IDLE;
      seen             <= '0;
      layer_finished_o <= 1'b0;
      timeout_o        <= 1'b0;
    end else begin
      case (state)
        MON_IDLE, MON_FIN: begin
          if (start) begin
            state            <= MON_RUN;
            seen             <= '0;
            layer_finished_o <= 1'b0;
            timeout_o        <= 1'b0;
          end
        end
        MON_RUN: begin
          seen <= seen | done_i;
          if (all_done) begin
            state            <= MON_FIN;
            layer_finished_o <= 1'b1;
          end else if (tmo_hit) begin
            // Marking all PEs seen freezes every unseen finish counter at n.
            state            <= MON_FIN;
            layer_finished_o <= 1'b1;
            timeout_o        <= 1'b1;
            seen             <= '1;
          end
        end
        default: state <= MON_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    if (rd_kind == RD_CYCLES) begin
      rd_mux = cycle_q;
    end else if (int'(rd_idx) < PE_NUMBER) begin
      case (rd_kind)
        RD_STALL:    rd_mux = stall_q[rd_idx];
        RD_CONFLICT: rd_mux = conf_q[rd_idx];
        default:     rd_mux = seen[rd_idx] ? fin_q[rd_idx] : '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end
endmodule

// File: tb/tb_noc_perf_monitor.sv
// Self-checking bench: directed and randomized layers against a per-layer arithmetic model.
module tb_noc_perf_monitor;
  import my_pkg::*;

  logic       clk = 1'b0, rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] done = '0, stall = '0, conf = '0;
  logic       rd_en = 1'b0;
  logic [1:0] rd_kind = '0, rd_idx = '0;
  logic       busy, lf, to, rd_valid;
  logic [7:0] rd_data;

  // auxiliary instance: 9 PEs, timeout disabled (saturation and out-of-range reads)
  logic       a_start = 1'b0;
  logic [8:0] a_done = '0, a_stall = '0, a_conf = '0;
  logic       a_rd_en = 1'b0;
  logic [1:0] a_rd_kind = '0;
  logic [3:0] a_rd_idx = '0;
  logic       a_busy, a_lf, a_to, a_rd_valid;
  logic [7:0] a_rd_data;

  int errs = 0, checks = 0;

  logic [3:0] dpat [1:30];
  logic [3:0] spat [1:30];
  logic [3:0] cpat [1:30];
  int fd [4];
  int exp_fin [4], exp_st [4], exp_cf [4];
  int e_end, exp_cyc;
  bit e_tmo;

  noc_perf_monitor #(.MESH_SIZE(2), .CNT_W(8), .TIMEOUT_CC(8'd20)) u_m (
    .clk(clk), .rst(rst), .start(start), .done_i(done), .stall_i(stall),
    .conflict_i(conf), .busy_o(busy), .layer_finished_o(lf), .timeout_o(to),
    .rd_en(rd_en), .rd_kind(rd_kind), .rd_idx(rd_idx), .rd_valid(rd_valid),
    .rd_data(rd_data)
  );

  noc_perf_monitor #(.MESH_SIZE(3), .CNT_W(8), .TIMEOUT_CC(8'd0)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .done_i(a_done), .stall_i(a_stall),
    .conflict_i(a_conf), .busy_o(a_busy), .layer_finished_o(a_lf), .timeout_o(a_to),
    .rd_en(a_rd_en), .rd_kind(a_rd_kind), .rd_idx(a_rd_idx), .rd_valid(a_rd_valid),
    .rd_data(a_rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  // Layer result from the rules: completion is the last first-done cycle,
  // capped at the timeout of 20; counts are taken over cycles 1..end.
  task automatic model();
    int last = 0;
    bit never = 0;
    for (int i = 0; i < 4; i++) begin
      fd[i] = 0;
      for (int c = 1; c <= 30; c++) if (fd[i] == 0 && dpat[c][i]) fd[i] = c;
      if (fd[i] == 0) never = 1;
      else if (fd[i] > last) last = fd[i];
    end
    e_tmo = never || (last > 20);
    e_end = e_tmo ? 20 : last;
    exp_cyc = e_end;
    for (int i = 0; i < 4; i++) begin
      exp_fin[i] = (fd[i] != 0 && fd[i] <= e_end) ? fd[i] : e_end;
      exp_st[i] = 0;
      exp_cf[i] = 0;
      for (int c = 1; c <= e_end; c++) begin
        exp_st[i] += int'(spat[c][i]);
        exp_cf[i] += int'(cpat[c][i]);
      end
    end
  endtask

  task automatic do_reads();
    int req = 0;
    for (int j = 0; j < 13; j++) begin
      rd_en = 1'b1;
      if (j == 0) begin
        rd_kind = RD_CYCLES;
        rd_idx  = 2'($urandom_range(0, 3));
        req = exp_cyc;
      end else begin
        rd_kind = 2'(((j - 1) % 3) + 1);
        rd_idx  = 2'((j - 1) / 3);
        case (rd_kind)
          RD_STALL:    req = exp_st[rd_idx];
          RD_CONFLICT: req = exp_cf[rd_idx];
          default:     req = exp_fin[rd_idx];
        endcase
      end
      tick();
      chk("rd_valid", rd_valid, 1);
      chk($sformatf("rd_data k%0d i%0d", rd_kind, rd_idx), rd_data, req);
    end
    rd_en = 1'b0;
    tick();
    chk("rd_valid_idle", rd_valid, 0);
    chk("rd_data_hold", rd_data, req);
  endtask

  task automatic run_layer(input bit mid_start);
    model();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("lf_clear_on_start", lf, 0);
    chk("to_clear_on_start", to, 0);
    for (int c = 1; c <= 30; c++) begin
      done  = dpat[c];
      stall = spat[c];
      conf  = cpat[c];
      start = mid_start && (c == 3) && (e_end > 3);
      rd_en = (c == 5);
      rd_kind = RD_CYCLES;
      tick();
      chk($sformatf("busy c%0d", c), busy, (c < e_end) ? 1 : 0);
      chk($sformatf("lf c%0d", c), lf, (c >= e_end) ? 1 : 0);
      if (c == 5) chk("rd_during_run", rd_data, (e_end < 5) ? e_end : 4);
    end
    start = 1'b0;
    rd_en = 1'b0;
    chk("timeout_o", to, e_tmo);
    // flags in FIN must not be counted
    for (int k = 0; k < 3; k++) begin
      done = 4'($urandom); stall = 4'($urandom); conf = 4'($urandom);
      tick();
    end
    do_reads();
  endtask

  task automatic clear_pats();
    for (int c = 1; c <= 30; c++) begin
      dpat[c] = '0; spat[c] = '0; cpat[c] = '0;
    end
  endtask

  task automatic aread(input string tag, input logic [1:0] k, input logic [3:0] idx, input int req);
    a_rd_en = 1'b1; a_rd_kind = k; a_rd_idx = idx;
    tick();
    a_rd_en = 1'b0;
    chk({tag, "_valid"}, a_rd_valid, 1);
    chk(tag, a_rd_data, req);
  endtask

  initial begin
    rst = 1'b1;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_lf", lf, 0);
    chk("rst_to", to, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;

    // IDLE activity that must not be counted
    stall = '1; conf = '1; done = '1;
    tick(); tick(); tick();

    // basic completion plus directed stall/conflict
    clear_pats();
    for (int c = 1; c <= 30; c++) begin
      dpat[c] = {c >= 10, c >= 10, c >= 5, c >= 3};
      spat[c][2] = (c >= 2 && c <= 8);
      cpat[c][1] = (c >= 4 && c <= 7);
    end
    run_layer(1'b0);
    chk("basic_fin0", exp_fin[0], 3);

    // timeout: PE 3 never finishes
    clear_pats();
    for (int c = 1; c <= 30; c++) dpat[c] = {1'b0, c >= 3, c >= 2, c >= 1};
    run_layer(1'b1);

    // completion exactly at the timeout cycle
    clear_pats();
    for (int c = 1; c <= 30; c++) begin
      dpat[c] = {c == 20, c >= 7, c == 4, c >= 1};
      spat[c] = 4'($urandom);
    end
    run_layer(1'b0);

    // randomized layers
    for (int l = 0; l < 6; l++) begin
      clear_pats();
      for (int i = 0; i < 4; i++) begin
        int f = $urandom_range(1, 24);
        for (int c = 1; c <= 30; c++)
          dpat[c][i] = (c == f) || (c > f && ($urandom_range(0, 1) == 1));
      end
      for (int c = 1; c <= 30; c++) begin
        spat[c] = 4'($urandom);
        cpat[c] = 4'($urandom);
      end
      run_layer(l[0]);
    end

    // saturation on the aux instance (timeout disabled)
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      a_stall = '0;
      a_stall[0] = 1'b1;
      a_stall[5] = (c <= 10);
      tick();
    end
    a_stall = '0;
    chk("a_busy", a_busy, 1);
    chk("a_to", a_to, 0);
    aread("a_stall0_sat", RD_STALL, 4'd0, 255);
    aread("a_cycle_sat", RD_CYCLES, 4'd7, 255);
    aread("a_stall5", RD_STALL, 4'd5, 10);
    aread("a_idx9", RD_STALL, 4'd9, 0);
    aread("a_idx15", RD_CONFLICT, 4'd15, 0);
    aread("a_fin_unseen", RD_FINISH, 4'd0, 0);

    // reset mid-RUN, with start held to confirm reset wins
    clear_pats();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      stall = 4'($urandom); conf = 4'($urandom); done = 4'b0001;
      tick();
    end
    rst = 1'b1; start = 1'b1;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_lf", lf, 0);
    chk("midrst_to", to, 0);
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_rd_data", rd_data, 0);
    rst = 1'b0; start = 1'b0;
    exp_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      exp_st[i] = 0; exp_cf[i] = 0; exp_fin[i] = 0;
    end
    do_reads();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
